// File: rtl/prbs_gen_param_if.sv
// Output stream bundle for prbs_gen_param.
//   out_data  : current word, driven by the source
//   out_valid : out_data is valid, driven by the source
//   out_ready : sink accepts out_data when out_valid && out_ready
// master = pattern source, slave = downstream sink.
interface prbs_gen_param_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/prbs_gen_param.sv
// Test-pattern source for link bring-up. After start it sends a captured
// preamble of PAT_WORDS words n+1 times, then a free-running Fibonacci
// LFSR stream until stop or reset.
//   CLK           : clock, rising edge
//   RST           : asynchronous active-high reset
//   start         : begin a sequence (honoured only in IDLE, stop=0)
//   stop          : abort to IDLE from any state, wins over everything
//   n             : preamble repeat count (sent n+1 times), captured on start
//   pattern       : preamble words, word 0 in the low bits, captured on start
//   strm          : valid/ready output stream (master side)
//   prbs_phase    : high while streaming LFSR words
//   preamble_done : pulse on the transfer of the final preamble word
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no output; waits for start
// PRE   | presents pat_words[word_idx]; rep_cnt counts finished passes
// PRBS  | presents low DATA_W bits of the LFSR, one shift per transfer
module prbs_gen_param #(
   parameter int                DATA_W    = 8,
   parameter int                PAT_WORDS = 4,
   parameter int                CNT_W     = 8,
   parameter int                LFSR_W    = 16,
   parameter int                TAP_A     = 14,
   parameter int                TAP_B     = 15,
   parameter logic [LFSR_W-1:0] SEED      = 16'h0011
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          start,
   input  logic                          stop,
   input  logic [CNT_W-1:0]              n,
   input  logic [PAT_WORDS*DATA_W-1:0]   pattern,
   prbs_gen_param_if.master              strm,
   output logic                          prbs_phase,
   output logic                          preamble_done
);

   localparam int IDX_W = (PAT_WORDS > 1) ? $clog2(PAT_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_PRBS = 2'd2
   } state_t;

   state_t             state, state_nx;
   logic [IDX_W-1:0]   word_idx, word_idx_nx;
   logic [CNT_W-1:0]   rep_cnt, rep_cnt_nx;
   logic [LFSR_W-1:0]  lfsr, lfsr_nx, lfsr_shift;
   logic [CNT_W-1:0]   n_reg;
   logic [DATA_W-1:0]  pat_words [PAT_WORDS];
   logic               load_cfg;
   logic               xfer;

   // Outputs decode from registered state only; out_ready never reaches them.
   always_comb begin
      strm.out_valid = 1'b0;
      strm.out_data  = '0;
      prbs_phase     = 1'b0;
      case (state)
         S_PRE: begin
            strm.out_valid = 1'b1;
            strm.out_data  = pat_words[word_idx];
         end
         S_PRBS: begin
            strm.out_valid = 1'b1;
            strm.out_data  = lfsr[DATA_W-1:0];
            prbs_phase     = 1'b1;
         end
         default: ;
      endcase
   end

   assign xfer       = strm.out_valid & strm.out_ready;
   assign lfsr_shift = {lfsr[LFSR_W-2:0], lfsr[TAP_A] ^ lfsr[TAP_B]};

   always_comb begin
      state_nx      = state;
      word_idx_nx   = word_idx;
      rep_cnt_nx    = rep_cnt;
      lfsr_nx       = lfsr;
      load_cfg      = 1'b0;
      preamble_done = 1'b0;
      if (stop) begin
         // A word presented in this cycle is treated as not taken.
         state_nx    = S_IDLE;
         word_idx_nx = '0;
         rep_cnt_nx  = '0;
         lfsr_nx     = SEED;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  load_cfg    = 1'b1;
                  word_idx_nx = '0;
                  rep_cnt_nx  = '0;
                  lfsr_nx     = SEED;
                  state_nx    = S_PRE;
               end
            end
            S_PRE: begin
               if (xfer) begin
                  if (word_idx != LAST_IDX) begin
                     word_idx_nx = word_idx + IDX_W'(1);
                  end else if (rep_cnt != n_reg) begin
                     // Compare before increment, so n = all-ones cannot wrap.
                     word_idx_nx = '0;
                     rep_cnt_nx  = rep_cnt + CNT_W'(1);
                  end else begin
                     preamble_done = 1'b1;
                     word_idx_nx   = '0;
                     rep_cnt_nx    = '0;
                     state_nx      = S_PRBS;
                  end
               end
            end
            S_PRBS: begin
               if (xfer) begin
                  lfsr_nx = lfsr_shift;
               end
            end
            default: state_nx = S_IDLE;
         endcase
         // All-zero is the LFSR's stuck state; kick it out unconditionally.
         if (lfsr == '0) begin
            lfsr_nx = LFSR_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= S_IDLE;
         word_idx <= '0;
         rep_cnt  <= '0;
         lfsr     <= SEED;
      end else begin
         state    <= state_nx;
         word_idx <= word_idx_nx;
         rep_cnt  <= rep_cnt_nx;
         lfsr     <= lfsr_nx;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         n_reg <= '0;
         for (int i = 0; i < PAT_WORDS; i++) begin
            pat_words[i] <= '0;
         end
      end else if (load_cfg) begin
         n_reg <= n;
         for (int i = 0; i < PAT_WORDS; i++) begin
            pat_words[i] <= pattern[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_prbs_gen_param.sv
// Bench for prbs_gen_param: stimulus pushes expected words into a queue,
// a negedge monitor pops and compares on every transfer.
module tb_prbs_gen_param;

   logic        CLK;
   logic        RST;
   logic        start;
   logic        stop;
   logic [7:0]  n;
   logic [31:0] pattern;
   logic        prbs_phase;
   logic        preamble_done;

   prbs_gen_param_if #(.DATA_W(8)) strm_if ();

   prbs_gen_param dut (
      .CLK           (CLK),
      .RST           (RST),
      .start         (start),
      .stop          (stop),
      .n             (n),
      .pattern       (pattern),
      .strm          (strm_if.master),
      .prbs_phase    (prbs_phase),
      .preamble_done (preamble_done)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       done;
      logic       phase;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Seed 0x0011, taps 14/15: feedback stays 0 for these, so it is a plain shift.
   logic [7:0] prbs_exp [8] = '{8'h11, 8'h22, 8'h44, 8'h88,
                                8'h10, 8'h20, 8'h40, 8'h80};

   localparam logic [31:0] PAT_A = 32'hDDCCBBAA;
   localparam logic [31:0] PAT_B = 32'h8C6B4A29;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   always @(negedge CLK) begin
      exp_t e;
      if (!RST && strm_if.out_valid && strm_if.out_ready && !stop) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_word got=%h required=none", strm_if.out_data);
         end else begin
            e = exp_q.pop_front();
            if (strm_if.out_data != e.data || preamble_done != e.done ||
                prbs_phase != e.phase) begin
               bad++;
               $display("FAIL stream_word got data=%h done=%b phase=%b required data=%h done=%b phase=%b",
                        strm_if.out_data, preamble_done, prbs_phase, e.data, e.done, e.phase);
            end
         end
      end else if (!RST && preamble_done) begin
         total++;
         bad++;
         $display("FAIL done_without_transfer got=1 required=0");
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_pre(input logic [31:0] p, input int reps);
      exp_t e;
      for (int r = 0; r <= reps; r++) begin
         for (int w = 0; w < 4; w++) begin
            e.data  = p[w*8 +: 8];
            e.done  = (r == reps) && (w == 3);
            e.phase = 1'b0;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic push_prbs(input int k);
      exp_t e;
      for (int i = 0; i < k; i++) begin
         e.data  = prbs_exp[i];
         e.done  = 1'b0;
         e.phase = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic do_start(input logic [31:0] p, input logic [7:0] cnt);
      pattern = p;
      n       = cnt;
      start   = 1'b1;
      @(posedge CLK); #1;
      start   = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int cyc = 0;
      while (exp_q.size() != 0) begin
         @(posedge CLK); #1;
         cyc++;
         if (cyc > budget && exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d_left required=0", exp_q.size());
            exp_q.delete();
         end
      end
   endtask

   task automatic stop_pulse();
      stop = 1'b1;
      @(posedge CLK); #1;
      stop = 1'b0;
      check("stop_valid", {31'd0, strm_if.out_valid}, 32'd0);
      check("stop_data", {24'd0, strm_if.out_data}, 32'd0);
      check("stop_phase", {31'd0, prbs_phase}, 32'd0);
   endtask

   task automatic wait_for_data(input logic [7:0] val, input int budget);
      int cyc = 0;
      while (!(strm_if.out_valid && strm_if.out_data == val)) begin
         @(posedge CLK); #1;
         cyc++;
         if (cyc > budget) begin
            total++;
            bad++;
            $display("FAIL wait_word got=%h required=%h", strm_if.out_data, val);
            return;
         end
      end
   endtask

   task automatic hold(input logic [7:0] val);
      strm_if.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         check("hold_valid", {31'd0, strm_if.out_valid}, 32'd1);
         check("hold_data", {24'd0, strm_if.out_data}, {24'd0, val});
      end
      strm_if.out_ready = 1'b1;
   endtask

   initial begin
      RST = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      n = '0;
      pattern = '0;
      strm_if.out_ready = 1'b1;

      #12;
      check("rst_valid", {31'd0, strm_if.out_valid}, 32'd0);
      check("rst_data", {24'd0, strm_if.out_data}, 32'd0);
      check("rst_phase", {31'd0, prbs_phase}, 32'd0);
      check("rst_done", {31'd0, preamble_done}, 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (2) begin
         @(posedge CLK); #1;
         check("idle_valid", {31'd0, strm_if.out_valid}, 32'd0);
      end

      // Two preamble passes then PRBS.
      push_pre(PAT_A, 1);
      push_prbs(6);
      do_start(PAT_A, 8'd1);
      wait_drain(100);
      stop_pulse();

      // Single pass, stop after 22, restart from AA and 11.
      push_pre(PAT_A, 0);
      push_prbs(2);
      do_start(PAT_A, 8'd0);
      wait_drain(100);
      stop_pulse();
      push_pre(PAT_A, 0);
      push_prbs(1);
      do_start(PAT_A, 8'd0);
      wait_drain(100);
      stop_pulse();

      // Backpressure in both phases.
      push_pre(PAT_A, 0);
      push_prbs(4);
      do_start(PAT_A, 8'd0);
      wait_for_data(8'hBB, 20);
      hold(8'hBB);
      wait_for_data(8'h44, 20);
      hold(8'h44);
      wait_drain(100);
      stop_pulse();

      // start together with stop stays in IDLE.
      start = 1'b1;
      stop  = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      stop  = 1'b0;
      check("start_stop_valid", {31'd0, strm_if.out_valid}, 32'd0);
      @(posedge CLK); #1;
      check("start_stop_valid2", {31'd0, strm_if.out_valid}, 32'd0);

      // start pulses and new inputs during PREAMBLE are ignored.
      push_pre(PAT_B, 1);
      push_prbs(2);
      do_start(PAT_B, 8'd1);
      repeat (2) @(posedge CLK);
      #1;
      pattern = 32'hFFFFFFFF;
      n = 8'd7;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      @(posedge CLK); #1;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      wait_drain(100);
      stop_pulse();

      // Maximum repeat count.
      push_pre(PAT_A, 255);
      push_prbs(1);
      do_start(PAT_A, 8'hFF);
      wait_drain(1200);
      stop_pulse();

      // Async reset mid-preamble.
      push_pre(PAT_A, 1);
      do_start(PAT_A, 8'd1);
      wait_for_data(8'hCC, 20);
      #3;
      RST = 1'b1;
      #1;
      check("arst_valid", {31'd0, strm_if.out_valid}, 32'd0);
      check("arst_data", {24'd0, strm_if.out_data}, 32'd0);
      check("arst_done", {31'd0, preamble_done}, 32'd0);
      exp_q.delete();
      @(posedge CLK);
      @(posedge CLK);
      #3;
      RST = 1'b0;
      repeat (3) begin
         @(posedge CLK); #1;
         check("post_rst_valid", {31'd0, strm_if.out_valid}, 32'd0);
      end
      push_pre(PAT_A, 0);
      push_prbs(2);
      do_start(PAT_A, 8'd0);
      wait_drain(100);
      stop_pulse();

      repeat (2) @(posedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prbs_gen_param.md
Name: prbs_gen_param

Overview:
- Parametrised test-pattern source for link bring-up.
- After `start`, it emits a fixed preamble pattern of `PAT_WORDS` words, `n+1` times over. It then switches to a free-running Fibonacci LFSR stream.
- Output uses a valid/ready handshake so downstream serialisers can apply backpressure.
- Adds start/stop control, configurable widths, taps and seed, a phase flag and a preamble-done pulse.

Parameters:
- DATA_W, 8, output word width in bits.
- PAT_WORDS, 4, number of DATA_W words in the preamble pattern (>=1).
- CNT_W, 8, width of the repeat-count input `n`.
- LFSR_W, 16, LFSR length in bits (>= DATA_W).
- TAP_A, 14, first feedback tap bit index.
- TAP_B, 15, second feedback tap bit index.
- SEED, 16'h0011, LFSR value loaded at reset, on `start` and on `stop` (LFSR_W bits, nonzero).

Ports:
- CLK, input, 1, clock; all state changes on rising edge.
- RST, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request to begin a sequence; sampled only in IDLE.
- stop, input, 1, abort; returns the block to IDLE from any state.
- n, input, CNT_W, preamble repeat count; the preamble is sent n+1 times. Captured on accepted `start`.
- pattern, input, PAT_WORDS*DATA_W, preamble words; word 0 = bits [DATA_W-1:0], sent first. Captured on accepted `start`.
- out_data, output, DATA_W, current word.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accepts out_data when out_valid && out_ready.
- prbs_phase, output, 1, 1 while in PRBS state.
- preamble_done, output, 1, one-cycle pulse on the transfer of the last preamble word.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, LFSR=SEED, word_idx=0, rep_cnt=0.
  - out_valid=0, out_data=0, prbs_phase=0, preamble_done=0.
- Transfer: a cycle with out_valid && out_ready. All counters and the LFSR advance only on a transfer.
- While out_valid=1 and out_ready=0, out_data holds stable.
- States:
  - IDLE:
    - out_valid=0, out_data=0.
    - start=1 and stop=0 -> capture n into n_reg and pattern into pat_reg; word_idx=0, rep_cnt=0, LFSR=SEED; next state PREAMBLE.
  - PREAMBLE:
    - out_valid=1, out_data=pat_reg word[word_idx].
    - On transfer with word_idx<PAT_WORDS-1: word_idx+1.
    - On transfer with word_idx=PAT_WORDS-1 and rep_cnt<n_reg: word_idx=0, rep_cnt+1.
    - On transfer with word_idx=PAT_WORDS-1 and rep_cnt==n_reg: preamble_done=1 that cycle (combinational with the transfer); next state PRBS.
  - PRBS:
    - out_valid=1, prbs_phase=1, out_data=LFSR[DATA_W-1:0].
    - On transfer: LFSR <= {LFSR[LFSR_W-2:0], LFSR[TAP_A]^LFSR[TAP_B]}, one shift per word.
    - Runs until stop or reset.
- out_data, out_valid and prbs_phase decode from registered state only, with no combinational path from out_ready. preamble_done is the only output that depends on out_ready.
- stop:
  - stop=1 in any state -> next state IDLE, LFSR=SEED, counters cleared.
  - stop has priority over start and over a simultaneous transfer. A word presented in that cycle counts as not transferred; the next word is not produced.
- start outside IDLE is ignored. Changes to n or pattern after capture have no effect until the next start.
- LFSR lock-up guard: if LFSR==0, next value is 1 regardless of transfer.
- Width rules:
  - rep_cnt is CNT_W bits. n=2^CNT_W-1 is legal (no overflow, since compare occurs before increment).
  - word_idx is clog2(PAT_WORDS) bits, minimum 1.
- PAT_WORDS=1: every preamble transfer is the last word of a repetition.
- RST asserted mid-operation: immediate return to reset values, no further words.

Test Plan:
- Basic sequence: reset, pattern=32'hDDCCBBAA, n=1, out_ready=1, start pulse.
  - Transfers: AA,BB,CC,DD,AA,BB,CC,DD, then 11,22,44,88,10,20.
  - preamble_done high only on the second DD.
  - prbs_phase rises with the 11 word.
- Single repetition: n=0, same pattern -> AA,BB,CC,DD then 11. preamble_done on DD.
- Backpressure: out_ready low for 3 cycles while BB is presented -> out_data stays BB and out_valid stays 1; sequence resumes with CC, no word lost or duplicated.
- Same backpressure in PRBS on the 44 word -> 44 held, then 88.
- Stop and restart: stop during PRBS after word 22.
  - Next cycle: out_valid=0.
  - start again -> preamble replays from AA and PRBS restarts at 11.
- Stop/start conflict:
  - start with stop=1 in IDLE -> stays IDLE.
  - start pulses during PREAMBLE -> ignored, counts unchanged.
- Async reset mid-PREAMBLE: RST asserted between clock edges -> out_valid drops immediately.
  - After release, no output until the next start.
  - The next run begins at AA with the LFSR at 0x0011.
